issue_ctrl: RTL and testbench

In-order issue controller between the decode stage and the execute stage. It holds a 32-entry register scoreboard and sequences the multi-cycle mul/div unit. It also drains the pipeline for `MISC_MEM` (fence) instructions and kills the decode-stage instruction on a control-flow redirect. Its `issue` and `stall` outputs gate the IF/ID pipeline register and the EX input latch.

---
 rtl/issue_ctrl.sv | 111 +++++++++++
 tb/tb_issue_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// In-order issue controller: register scoreboard, mul/div sequencing, fence drain
// and redirect kill. Decides each cycle whether the ID instruction moves to EX.
module issue_ctrl #(
  parameter int MULDIV_CYCLES = 33,
  parameter int CNT_W         = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_muldiv,
  input  logic        id_fence,
  input  logic        ex_redirect,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        issue,
  output logic        stall,
  output logic        kill_id,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic        fence_pulse,
  output logic [31:0] pending
);

  // Handshake: ID offers an instruction with id_valid; issue is the same-cycle
  // accept. stall is asserted exactly when a live (non-killed) offer is not accepted.

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  // The mul/div FSM state is directly observable on muldiv_busy.
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pending_q, pending_d;
  logic [31:0]      wb_clr, eff, id_set;
  logic             raw, mdblock, fence_hold, md_start, cnt_zero;

  // Register file is write-first, so the retiring write already resolves hazards.
  assign wb_clr   = wb_valid ? (32'd1 << wb_rd) : 32'd0;
  assign eff      = pending_q & ~wb_clr;
  assign raw      = ((id_rs1 != 5'd0) && eff[id_rs1]) ||
                    ((id_rs2 != 5'd0) && eff[id_rs2]);
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    muldiv_busy = (state_q == MD_BUSY);
    muldiv_done = muldiv_busy && cnt_zero;
    mdblock     = muldiv_busy && !muldiv_done;
    fence_hold  = id_fence && ((eff != 32'd0) || mdblock);
    kill_id     = ex_redirect;
    issue       = id_valid && !kill_id && !raw && !mdblock && !fence_hold;
    stall       = id_valid && !kill_id && !issue;
    fence_pulse = issue && id_fence;
    md_start    = issue && id_muldiv;
    pending     = pending_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_zero) begin
          // Back-to-back mul/div may issue in the done cycle and reloads.
          if (md_start) begin
            state_d = MD_BUSY;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = MD_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Set after clear so a same-register issue keeps its bit; x0 never tracked.
  assign id_set    = (issue && (id_rd != 5'd0)) ? (32'd1 << id_rd) : 32'd0;
  assign pending_d = (eff | id_set) & 32'hFFFF_FFFE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: a vector table for single-cycle behaviour plus
// hand-written multi-cycle sequences for mul/div, back-to-back and reset abort.
module tb_issue_ctrl;

  localparam int MD = 33;
  localparam int W  = 38;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid, id_muldiv, id_fence, ex_redirect, wb_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        issue, stall, kill_id, muldiv_busy, muldiv_done, fence_pulse;
  logic [31:0] pending;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       md;
    logic       fence;
    logic       redir;
    logic       wbv;
    logic [4:0] wbrd;
  } in_t;

  typedef struct packed {
    in_t          in;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  issue_ctrl #(.MULDIV_CYCLES(MD), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_muldiv(id_muldiv), .id_fence(id_fence), .ex_redirect(ex_redirect),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue(issue), .stall(stall), .kill_id(kill_id),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .fence_pulse(fence_pulse), .pending(pending)
  );

  // Clock / reset
  always #5 clock = ~clock;

  function automatic in_t mk_in(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic md, logic fence, logic redir, logic wbv, logic [4:0] wbrd);
    in_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.md = md;
    r.fence = fence; r.redir = redir; r.wbv = wbv; r.wbrd = wbrd;
    return r;
  endfunction

  function automatic logic [W-1:0] ex(logic iss, logic stl, logic kil, logic bsy,
                                      logic dn, logic fp, logic [31:0] pend);
    return {iss, stl, kil, bsy, dn, fp, pend};
  endfunction

  // Drivers
  task automatic apply(input in_t in);
    id_valid    = in.v;
    id_rs1      = in.rs1;
    id_rs2      = in.rs2;
    id_rd       = in.rd;
    id_muldiv   = in.md;
    id_fence    = in.fence;
    ex_redirect = in.redir;
    wb_valid    = in.wbv;
    wb_rd       = in.wbrd;
  endtask

  // Scoreboard compare
  task automatic check(input string name);
    logic [W-1:0] e, a;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = exp_q.pop_front();
    a = {issue, stall, kill_id, muldiv_busy, muldiv_done, fence_pulse, pending};
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got iss/stl/kil/bsy/dn/fp=%b pending=%h, expected %b pending=%h",
               name, a[W-1:32], a[31:0], e[W-1:32], e[31:0]);
    end
  endtask

  // Called at posedge+1: drive, expect, sample at negedge, advance one cycle.
  task automatic step(input string name, input in_t in, input logic [W-1:0] e);
    apply(in);
    exp_q.push_back(e);
    @(negedge clock);
    check(name);
    @(posedge clock);
    #1;
  endtask

  initial begin
    in_t         idle;
    logic [31:0] p;
    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single-cycle vector table
    vecs.push_back('{mk_in(1, 0, 0, 5, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 32'h0)});
    vecs.push_back('{mk_in(1, 6, 0, 7, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 32'h20)});
    vecs.push_back('{idle,                             ex(0, 0, 0, 0, 0, 0, 32'hA0)});
    vecs.push_back('{mk_in(1, 0, 5, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 32'hA0)});
    vecs.push_back('{mk_in(1, 0, 5, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 32'hA0)});
    vecs.push_back('{mk_in(1, 0, 5, 0, 0, 0, 0, 1, 5), ex(1, 0, 0, 0, 0, 0, 32'hA0)});
    vecs.push_back('{idle,                             ex(0, 0, 0, 0, 0, 0, 32'h80)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 7), ex(0, 0, 0, 0, 0, 0, 32'h80)});
    vecs.push_back('{idle,                             ex(0, 0, 0, 0, 0, 0, 32'h0)});
    vecs.push_back('{mk_in(1, 0, 0, 8, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 32'h0)});
    vecs.push_back('{mk_in(1, 0, 0, 0, 0, 1, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 32'h100)});
    vecs.push_back('{mk_in(1, 0, 0, 0, 0, 1, 0, 0, 0), ex(0, 1, 0, 0, 0, 0, 32'h100)});
    vecs.push_back('{mk_in(1, 0, 0, 0, 0, 1, 0, 1, 8), ex(1, 0, 0, 0, 0, 1, 32'h100)});
    vecs.push_back('{idle,                             ex(0, 0, 0, 0, 0, 0, 32'h0)});
    vecs.push_back('{mk_in(1, 0, 0, 9, 1, 0, 1, 0, 0), ex(0, 0, 1, 0, 0, 0, 32'h0)});
    vecs.push_back('{idle,                             ex(0, 0, 0, 0, 0, 0, 32'h0)});
    vecs.push_back('{mk_in(1, 0, 0, 3, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 32'h0)});
    vecs.push_back('{mk_in(1, 0, 0, 3, 0, 0, 0, 1, 3), ex(1, 0, 0, 0, 0, 0, 32'h8)});
    vecs.push_back('{idle,                             ex(0, 0, 0, 0, 0, 0, 32'h8)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 3), ex(0, 0, 0, 0, 0, 0, 32'h8)});
    vecs.push_back('{idle,                             ex(0, 0, 0, 0, 0, 0, 32'h0)});
    vecs.push_back('{mk_in(1, 0, 0, 4, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 32'h0)});
    vecs.push_back('{mk_in(1, 4, 0, 6, 0, 0, 1, 0, 0), ex(0, 0, 1, 0, 0, 0, 32'h10)});
    vecs.push_back('{idle,                             ex(0, 0, 0, 0, 0, 0, 32'h10)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 4), ex(0, 0, 0, 0, 0, 0, 32'h10)});
    vecs.push_back('{idle,                             ex(0, 0, 0, 0, 0, 0, 32'h0)});
    vecs.push_back('{mk_in(1, 0, 0, 0, 0, 0, 0, 1, 0), ex(1, 0, 0, 0, 0, 0, 32'h0)});
    vecs.push_back('{idle,                             ex(0, 0, 0, 0, 0, 0, 32'h0)});

    // Reset state
    reset = 1'b1;
    apply(idle);
    #2;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 32'h0));
    check("reset_state");
    @(posedge clock);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) step($sformatf("vec[%0d]", i), vecs[i].in, vecs[i].exp);

    // Mul/div with a waiting independent instruction
    step("md_issue", mk_in(1, 0, 0, 10, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 32'h0));
    for (int k = 1; k <= MD; k++)
      step($sformatf("md_wait[%0d]", k), mk_in(1, 0, 0, 11, 0, 0, 0, 0, 0),
           ex(k == MD, k != MD, 0, 1, k == MD, 0, 32'h400));
    step("md_after", idle, ex(0, 0, 0, 0, 0, 0, 32'hC00));
    step("md_wb10", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 10), ex(0, 0, 0, 0, 0, 0, 32'hC00));
    step("md_wb11", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 11), ex(0, 0, 0, 0, 0, 0, 32'h800));
    step("md_clean", idle, ex(0, 0, 0, 0, 0, 0, 32'h0));

    // Back-to-back mul/div: busy continuous across both ops
    step("b2b_issue", mk_in(1, 0, 0, 0, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 32'h0));
    for (int k = 1; k <= MD; k++)
      step($sformatf("b2b_first[%0d]", k), mk_in(1, 0, 0, 0, 1, 0, 0, 0, 0),
           ex(k == MD, k != MD, 0, 1, k == MD, 0, 32'h0));
    for (int k = MD + 1; k <= 2 * MD; k++)
      step($sformatf("b2b_second[%0d]", k), idle, ex(0, 0, 0, 1, k == 2 * MD, 0, 32'h0));
    step("b2b_idle", idle, ex(0, 0, 0, 0, 0, 0, 32'h0));

    // Fill scoreboard with x1..x15, then start a mul/div and abort with reset
    for (int i = 1; i <= 15; i++) begin
      p = ((32'd1 << i) - 32'd1) & 32'hFFFF_FFFE;
      step($sformatf("fill[%0d]", i), mk_in(1, 0, 0, 5'(i), 0, 0, 0, 0, 0),
           ex(1, 0, 0, 0, 0, 0, p));
    end
    step("abort_md_issue", mk_in(1, 0, 0, 0, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 32'hFFFE));
    for (int k = 0; k < 3; k++)
      step($sformatf("abort_busy[%0d]", k), idle, ex(0, 0, 0, 1, 0, 0, 32'hFFFE));
    reset = 1'b1;
    #1;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 32'h0));
    check("reset_midop");
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < MD + 2; k++)
      step($sformatf("post_reset[%0d]", k), idle, ex(0, 0, 0, 0, 0, 0, 32'h0));
    step("post_reset_issue", mk_in(1, 0, 0, 2, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 32'h0));
    step("post_reset_pend", idle, ex(0, 0, 0, 0, 0, 0, 32'h4));

    // Final report
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
